ahb_resp_mux: RTL and testbench

- AHB slave-to-master response multiplexer with a built-in default slave and a wait-state watchdog.
- Sits directly downstream of the ROM, SRAM, AHB-to-APB bridge and DMA register slaves, and upstream of the master mux.
- Registers the address-phase decoder select, then steers the selected slave's HRDATA/HREADYOUT/HRESP onto the shared bus during the data phase.
- Answers unmapped or ambiguous accesses, and slaves stalled too long, with a protocol-correct two-cycle ERROR response.

---
 rtl/soc_ahb_pkg.sv | 24 ++
 rtl/ahb_default_slave.sv | 49 ++++
 rtl/ahb_resp_mux.sv | 141 ++++++++++++++
 tb/tb_ahb_resp_mux.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_ahb_pkg.sv
// Shared AHB encodings for the SoC fabric: transfer types, response codes,
// default-slave states and error-cause codes.
package soc_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  localparam logic ERR_CAUSE_UNMAPPED = 1'b0;
  localparam logic ERR_CAUSE_TIMEOUT  = 1'b1;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: emits the two-cycle AHB ERROR response after a start pulse.
// Latency: ERR1 the cycle after start, ERR2 the one after; start in ERR2 chains into ERR1.
// Backpressure: drives HREADY low only in ERR1; ignores bus HREADY.
module ahb_default_slave
  import soc_ahb_pkg::*;
(
  input  logic HCLK,
  input  logic HRESETn,
  input  logic start,
  output logic ds_hready,
  output logic ds_hresp,
  output logic busy
);

  ds_state_e state_q, state_d;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= DS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ds_hready = 1'b1;
    ds_hresp  = HRESP_OKAY;
    busy      = 1'b0;
    case (state_q)
      DS_IDLE: begin
        if (start) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        ds_hready = 1'b0;
        ds_hresp  = HRESP_ERROR;
        busy      = 1'b1;
        state_d   = DS_ERR2;
      end
      DS_ERR2: begin
        ds_hresp = HRESP_ERROR;
        busy     = 1'b1;
        state_d  = start ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB slave response mux with default slave, wait-state watchdog and error capture.
// Latency: zero added on the data phase (slave signals pass combinationally).
// Backpressure: selected slave's HREADYOUT drives HREADY; watchdog forces ERROR on long stalls.
module ahb_resp_mux
  import soc_ahb_pkg::*;
#(
  parameter int NSLV           = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [31:0]                HADDR,
  input  logic [1:0]                 HTRANS,
  input  logic [NSLV-1:0]            slv_sel,
  input  logic [NSLV*DATA_WIDTH-1:0] slv_hrdata,
  input  logic [NSLV-1:0]            slv_hreadyout,
  input  logic [NSLV-1:0]            slv_hresp,
  output logic [DATA_WIDTH-1:0]      HRDATA,
  output logic                       HREADY,
  output logic                       HRESP,
  output logic                       err_valid,
  output logic                       err_cause,
  output logic [31:0]                err_addr,
  input  logic                       err_clr
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Counter stops at the timeout threshold; with the watchdog disabled it just saturates.
  localparam logic [CW-1:0] CNT_SAT = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '1;

  logic [NSLV-1:0]       dsel_q;
  logic [31:0]           haddr_q;
  logic [CW-1:0]         wait_cnt_q;

  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  sel_rdy;
  logic                  sel_resp;
  logic                  sel_onehot;
  logic                  xfer_vld;
  logic                  accept;
  logic                  unmapped_start;
  logic                  stall;
  logic                  timeout;
  logic                  ds_start;
  logic                  ds_hready;
  logic                  ds_hresp;
  logic                  ds_busy;
  htrans_e               htrans;

  assign htrans     = htrans_e'(HTRANS);
  assign xfer_vld   = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  assign sel_onehot = (slv_sel != '0) && ((slv_sel & (slv_sel - NSLV'(1))) == '0);

  // dsel_q is only ever loaded one-hot, so an AND-OR mux is exact.
  always_comb begin
    sel_rdata = '0;
    sel_rdy   = 1'b0;
    sel_resp  = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (dsel_q[i]) begin
        sel_rdata = sel_rdata | slv_hrdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_rdy   = sel_rdy | slv_hreadyout[i];
        sel_resp  = sel_resp | slv_hresp[i];
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    if (ds_busy) begin
      HREADY = ds_hready;
      HRESP  = ds_hresp;
    end else if (dsel_q != '0) begin
      HRDATA = sel_rdata;
      HREADY = sel_rdy;
      HRESP  = sel_resp;
    end
  end

  assign accept         = xfer_vld && HREADY;
  assign unmapped_start = accept && !sel_onehot;
  assign stall          = (dsel_q != '0) && !ds_busy && !sel_rdy;
  assign timeout        = (TIMEOUT_CYCLES != 0) && stall && (wait_cnt_q == CNT_SAT);
  assign ds_start       = unmapped_start || timeout;

  ahb_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .start     (ds_start),
    .ds_hready (ds_hready),
    .ds_hresp  (ds_hresp),
    .busy      (ds_busy)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_q  <= '0;
      haddr_q <= '0;
    end else begin
      if (timeout) begin
        dsel_q <= '0;
      end else if (HREADY) begin
        dsel_q <= (accept && sel_onehot) ? slv_sel : '0;
      end
      if (accept) begin
        haddr_q <= HADDR;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt_q <= '0;
    end else if (HREADY) begin
      wait_cnt_q <= '0;
    end else if (stall && (wait_cnt_q != CNT_SAT)) begin
      wait_cnt_q <= wait_cnt_q + CW'(1);
    end
  end

  // A new error on the clearing edge reloads the capture registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_valid <= 1'b0;
      err_cause <= ERR_CAUSE_UNMAPPED;
      err_addr  <= '0;
    end else if (ds_start && (!err_valid || err_clr)) begin
      err_valid <= 1'b1;
      err_cause <= timeout ? ERR_CAUSE_TIMEOUT : ERR_CAUSE_UNMAPPED;
      err_addr  <= timeout ? haddr_q : HADDR;
    end else if (err_clr) begin
      err_valid <= 1'b0;
      err_cause <= ERR_CAUSE_UNMAPPED;
      err_addr  <= '0;
    end
  end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Bench for ahb_resp_mux: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against a transaction-level reference model.
module tb_ahb_resp_mux;
  import soc_ahb_pkg::*;

  localparam int NSLV = 4;
  localparam int DW   = 32;
  localparam int TO   = 8;

  logic              HCLK = 1'b0;
  logic              HRESETn = 1'b1;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic [NSLV-1:0]   slv_sel;
  logic [NSLV*DW-1:0] slv_hrdata;
  logic [NSLV-1:0]   slv_hreadyout;
  logic [NSLV-1:0]   slv_hresp;
  logic [DW-1:0]     HRDATA;
  logic              HREADY;
  logic              HRESP;
  logic              err_valid;
  logic              err_cause;
  logic [31:0]       err_addr;
  logic              err_clr;

  int n_cmp = 0;
  int n_bad = 0;

  ahb_resp_mux #(.NSLV(NSLV), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .slv_sel(slv_sel), .slv_hrdata(slv_hrdata), .slv_hreadyout(slv_hreadyout),
    .slv_hresp(slv_hresp), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .err_valid(err_valid), .err_cause(err_cause), .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: which slave owns the data phase (-1 = none), error-response step
  // (0 none, 1 first ERROR cycle, 2 second), consecutive stall count, error record.
  int          m_sel, m_ds, m_cnt;
  logic [31:0] m_aq, m_ea;
  bit          m_ev, m_ec;

  task automatic model_reset();
    m_sel = -1; m_ds = 0; m_cnt = 0; m_aq = '0; m_ev = 0; m_ec = 0; m_ea = '0;
  endtask

  initial begin
    logic        e_rdy, e_resp, acc, unm, stl, tmo;
    logic [31:0] e_data;
    int          ones, idx;
    model_reset();
    forever begin
      @(negedge HCLK or negedge HRESETn);
      if (!HRESETn) model_reset();
      if (HCLK) continue;
      e_data = '0; e_rdy = 1'b1; e_resp = 1'b0;
      if (m_ds == 1) begin
        e_rdy = 1'b0; e_resp = 1'b1;
      end else if (m_ds == 2) begin
        e_resp = 1'b1;
      end else if (m_sel >= 0) begin
        e_data = slv_hrdata[m_sel*DW +: DW];
        e_rdy  = slv_hreadyout[m_sel];
        e_resp = slv_hresp[m_sel];
      end
      chk("hrdata", HRDATA, e_data);
      chk("hready", 32'(HREADY), 32'(e_rdy));
      chk("hresp", 32'(HRESP), 32'(e_resp));
      chk("err_valid", 32'(err_valid), 32'(m_ev));
      chk("err_cause", 32'(err_cause), 32'(m_ec));
      chk("err_addr", err_addr, m_ea);
      if (HRESETn) begin
        ones = $countones(slv_sel);
        idx = -1;
        for (int i = 0; i < NSLV; i++) if (slv_sel[i]) idx = i;
        acc = HTRANS[1] && e_rdy;
        unm = acc && (ones != 1);
        stl = (m_ds == 0) && (m_sel >= 0) && !e_rdy;
        tmo = stl && (m_cnt >= TO - 1);
        if ((unm || tmo) && (!m_ev || err_clr)) begin
          m_ev = 1; m_ec = tmo; m_ea = tmo ? m_aq : HADDR;
        end else if (err_clr) begin
          m_ev = 0; m_ec = 0; m_ea = '0;
        end
        if (acc) m_aq = HADDR;
        if (e_rdy) m_cnt = 0;
        else if (stl && m_cnt < TO - 1) m_cnt = m_cnt + 1;
        if (tmo) m_sel = -1;
        else if (e_rdy) m_sel = (acc && ones == 1) ? idx : -1;
        m_ds = (unm || tmo) ? 1 : ((m_ds == 1) ? 2 : 0);
      end
    end
  end

  task automatic cyc(input logic [1:0] tr, input logic [3:0] sel, input logic [31:0] a,
                     input logic [3:0] rdy, input logic [3:0] rsp, input bit clr);
    @(posedge HCLK); #1;
    HTRANS = tr; slv_sel = sel; HADDR = a;
    slv_hreadyout = rdy; slv_hresp = rsp; err_clr = clr;
  endtask

  task automatic set_fixed_data();
    slv_hrdata[0*DW +: DW] = 32'hDEAD_BEEF;
    for (int i = 1; i < NSLV; i++) slv_hrdata[i*DW +: DW] = 32'h1111_1111 * (i + 1);
  endtask

  initial begin
    int r, stuck, stuck_left;
    HTRANS = HTRANS_IDLE; slv_sel = '0; HADDR = '0; slv_hreadyout = '1;
    slv_hresp = '0; err_clr = 1'b0;
    set_fixed_data();
    @(posedge HCLK); #1 HRESETn = 1'b0;
    @(posedge HCLK); #1 HRESETn = 1'b1;
    @(negedge HCLK);
    chk("rst_hready", 32'(HREADY), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_err_valid", 32'(err_valid), 32'd0);

    // ROM read, zero wait
    cyc(HTRANS_NONSEQ, 4'b0001, 32'h10, 4'hF, 4'h0, 0);
    cyc(HTRANS_IDLE, 4'b0000, 32'h0, 4'hF, 4'h0, 0);
    @(negedge HCLK);
    chk("rom_data", HRDATA, 32'hDEAD_BEEF);
    chk("rom_hready", 32'(HREADY), 32'd1);
    chk("rom_hresp", 32'(HRESP), 32'd0);

    // SRAM: three wait states then the slave's own two-cycle ERROR
    cyc(HTRANS_NONSEQ, 4'b0010, 32'h2000_0000, 4'hF, 4'h0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(HTRANS_IDLE, 4'b0000, 32'h0, 4'b1101, 4'h0, 0);
      @(negedge HCLK);
      chk("sram_wait_hready", 32'(HREADY), 32'd0);
    end
    cyc(HTRANS_IDLE, 4'b0000, 32'h0, 4'b1101, 4'b0010, 0);
    @(negedge HCLK);
    chk("sram_err1_hready", 32'(HREADY), 32'd0);
    chk("sram_err1_hresp", 32'(HRESP), 32'd1);
    cyc(HTRANS_IDLE, 4'b0000, 32'h0, 4'hF, 4'b0010, 0);
    @(negedge HCLK);
    chk("sram_err2_hready", 32'(HREADY), 32'd1);
    chk("sram_err2_hresp", 32'(HRESP), 32'd1);
    cyc(HTRANS_IDLE, 4'b0000, 32'h0, 4'hF, 4'h0, 0);
    @(negedge HCLK);
    chk("sram_err_valid", 32'(err_valid), 32'd0);

    // Unmapped, then ambiguous select, each cleared afterwards
    for (int k = 0; k < 2; k++) begin
      cyc(HTRANS_NONSEQ, (k == 0) ? 4'b0000 : 4'b0110, (k == 0) ? 32'h9000_0000 : 32'h1234_5678,
          4'hF, 4'h0, 0);
      cyc(HTRANS_IDLE, 4'b0000, 32'h0, 4'hF, 4'h0, 0);
      @(negedge HCLK);
      chk("unm_err1_hready", 32'(HREADY), 32'd0);
      chk("unm_err1_hresp", 32'(HRESP), 32'd1);
      cyc(HTRANS_IDLE, 4'b0000, 32'h0, 4'hF, 4'h0, 0);
      @(negedge HCLK);
      chk("unm_err2_hready", 32'(HREADY), 32'd1);
      chk("unm_err2_hresp", 32'(HRESP), 32'd1);
      chk("unm_err_valid", 32'(err_valid), 32'd1);
      chk("unm_err_cause", 32'(err_cause), 32'd0);
      chk("unm_err_addr", err_addr, (k == 0) ? 32'h9000_0000 : 32'h1234_5678);
      cyc(HTRANS_IDLE, 4'b0000, 32'h0, 4'hF, 4'h0, 1);
      cyc(HTRANS_IDLE, 4'b0000, 32'h0, 4'hF, 4'h0, 0);
      @(negedge HCLK);
      chk("clr_err_valid", 32'(err_valid), 32'd0);
    end

    // Bridge stuck: watchdog fires after TO wait states
    cyc(HTRANS_NONSEQ, 4'b0100, 32'h4000_0100, 4'hF, 4'h0, 0);
    for (int i = 1; i <= TO + 1; i++) begin
      cyc(HTRANS_IDLE, 4'b0000, 32'h0, 4'b1011, 4'h0, 0);
      @(negedge HCLK);
      chk("tmo_hready", 32'(HREADY), 32'd0);
      chk("tmo_hresp", 32'(HRESP), (i <= TO) ? 32'd0 : 32'd1);
    end
    cyc(HTRANS_NONSEQ, 4'b0001, 32'h20, 4'b1011, 4'h0, 0);
    @(negedge HCLK);
    chk("tmo_err2_hready", 32'(HREADY), 32'd1);
    chk("tmo_err2_hresp", 32'(HRESP), 32'd1);
    chk("tmo_err_cause", 32'(err_cause), 32'd1);
    chk("tmo_err_addr", err_addr, 32'h4000_0100);
    cyc(HTRANS_IDLE, 4'b0000, 32'h0, 4'b1011, 4'h0, 0);
    @(negedge HCLK);
    chk("post_tmo_rom_data", HRDATA, 32'hDEAD_BEEF);
    chk("post_tmo_rom_hresp", 32'(HRESP), 32'd0);

    // Back-to-back unmapped; the ERR2-cycle transfer re-enters ERR1, first address kept
    cyc(HTRANS_NONSEQ, 4'b0000, 32'hA000_0000, 4'hF, 4'h0, 0);
    cyc(HTRANS_NONSEQ, 4'b0000, 32'hB000_0000, 4'hF, 4'h0, 0);
    @(negedge HCLK);
    chk("b2b_err1_hready", 32'(HREADY), 32'd0);
    cyc(HTRANS_NONSEQ, 4'b0000, 32'hB000_0000, 4'hF, 4'h0, 0);
    @(negedge HCLK);
    chk("b2b_err2_hready", 32'(HREADY), 32'd1);
    cyc(HTRANS_IDLE, 4'b0000, 32'h0, 4'hF, 4'h0, 0);
    @(negedge HCLK);
    chk("b2b_reerr1_hready", 32'(HREADY), 32'd0);
    chk("b2b_reerr1_hresp", 32'(HRESP), 32'd1);
    chk("b2b_err_addr", err_addr, 32'h4000_0100);
    cyc(HTRANS_IDLE, 4'b0000, 32'h0, 4'hF, 4'h0, 0);
    cyc(HTRANS_IDLE, 4'b0000, 32'h0, 4'hF, 4'h0, 0);

    // Clear and new error on the same edge: new error wins
    cyc(HTRANS_NONSEQ, 4'b0000, 32'hC000_0000, 4'hF, 4'h0, 1);
    cyc(HTRANS_IDLE, 4'b0000, 32'h0, 4'hF, 4'h0, 0);
    @(negedge HCLK);
    chk("clrwin_err_valid", 32'(err_valid), 32'd1);
    chk("clrwin_err_addr", err_addr, 32'hC000_0000);
    chk("clrwin_err_cause", 32'(err_cause), 32'd0);
    cyc(HTRANS_IDLE, 4'b0000, 32'h0, 4'hF, 4'h0, 0);
    cyc(HTRANS_IDLE, 4'b0000, 32'h0, 4'hF, 4'h0, 0);

    // Reset pulse during ERR1
    cyc(HTRANS_NONSEQ, 4'b0000, 32'hD000_0000, 4'hF, 4'h0, 0);
    cyc(HTRANS_IDLE, 4'b0000, 32'h0, 4'hF, 4'h0, 0);
    #1;
    chk("pre_rst_err1_hready", 32'(HREADY), 32'd0);
    HRESETn = 1'b0;
    #1;
    chk("async_rst_hready", 32'(HREADY), 32'd1);
    chk("async_rst_hresp", 32'(HRESP), 32'd0);
    chk("async_rst_err_valid", 32'(err_valid), 32'd0);
    chk("async_rst_err_addr", err_addr, 32'd0);
    @(posedge HCLK); #2 HRESETn = 1'b1;
    cyc(HTRANS_NONSEQ, 4'b0001, 32'h10, 4'hF, 4'h0, 0);
    cyc(HTRANS_IDLE, 4'b0000, 32'h0, 4'hF, 4'h0, 0);
    @(negedge HCLK);
    chk("post_rst_data", HRDATA, 32'hDEAD_BEEF);
    chk("post_rst_hresp", 32'(HRESP), 32'd0);
    chk("post_rst_err_valid", 32'(err_valid), 32'd0);

    // Randomized traffic with occasional stuck slaves, clears and resets
    stuck = 0; stuck_left = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge HCLK); #1;
      if (!HRESETn) HRESETn = 1'b1;
      else if ($urandom_range(0, 399) == 0) HRESETn = 1'b0;
      r = $urandom_range(0, 9);
      HTRANS = (r < 6) ? HTRANS_NONSEQ : (r < 8) ? HTRANS_IDLE : (r < 9) ? HTRANS_SEQ : HTRANS_BUSY;
      r = $urandom_range(0, 99);
      slv_sel = (r < 80) ? 4'(1 << $urandom_range(0, 3)) : (r < 90) ? 4'b0000 : 4'($urandom);
      HADDR = $urandom;
      if (stuck_left == 0 && $urandom_range(0, 29) == 0) begin
        stuck = $urandom_range(0, 3);
        stuck_left = $urandom_range(5, 20);
      end
      for (int i = 0; i < NSLV; i++) begin
        slv_hreadyout[i] = ($urandom_range(0, 3) != 0) && !(stuck_left > 0 && stuck == i);
        slv_hresp[i] = ($urandom_range(0, 9) == 0);
        slv_hrdata[i*DW +: DW] = $urandom;
      end
      if (stuck_left > 0) stuck_left--;
      err_clr = ($urandom_range(0, 19) == 0);
    end
    @(posedge HCLK); #1;
    HRESETn = 1'b1; HTRANS = HTRANS_IDLE; err_clr = 1'b0;
    repeat (4) @(posedge HCLK);
    @(negedge HCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
